// File: rtl/gauss_window_3x3.sv
// Streaming 3x3 neighbourhood generator that feeds the Gaussian adder tree.
// Two line buffers hold the previous rows; a registered window is produced for every interior pixel.
module gauss_window_3x3 #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sof,
    input  logic [DATA_WIDTH-1:0]   in_pixel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [9*DATA_WIDTH-1:0] out_window,
    output logic                    out_last
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    logic [DATA_WIDTH-1:0]   lb0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0]   lb1 [IMG_WIDTH];
    logic [COL_W-1:0]        col;
    logic [ROW_W-1:0]        row;
    logic [COL_W-1:0]        cur_col;
    logic [ROW_W-1:0]        cur_row;
    logic [DATA_WIDTH-1:0]   tap_a;
    logic [DATA_WIDTH-1:0]   tap_b;
    logic [9*DATA_WIDTH-1:0] win_q;
    logic [9*DATA_WIDTH-1:0] next_win;
    logic                    accept;
    logic                    produce;
    logic                    last_pix;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A start-of-frame pixel is placed at (0,0) whatever the counters say.
    always_comb begin
        cur_col  = in_sof ? '0 : col;
        cur_row  = in_sof ? '0 : row;
        tap_a    = lb1[cur_col];
        tap_b    = lb0[cur_col];
        produce  = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
        last_pix = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        next_win = '0;
        for (int r = 0; r < 3; r++) begin
            next_win[(3*r)*DATA_WIDTH +: DATA_WIDTH]   = win_q[(3*r+1)*DATA_WIDTH +: DATA_WIDTH];
            next_win[(3*r+1)*DATA_WIDTH +: DATA_WIDTH] = win_q[(3*r+2)*DATA_WIDTH +: DATA_WIDTH];
        end
        next_win[2*DATA_WIDTH +: DATA_WIDTH] = tap_a;
        next_win[5*DATA_WIDTH +: DATA_WIDTH] = tap_b;
        next_win[8*DATA_WIDTH +: DATA_WIDTH] = in_pixel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            win_q      <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_window <= '0;
        end else begin
            if (accept) begin
                win_q <= next_win;
                if (cur_col == COL_LAST) begin
                    col <= '0;
                    row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
                end else begin
                    col <= cur_col + 1'b1;
                    row <= cur_row;
                end
            end
            // A fresh window may replace the one being emitted in the same cycle.
            if (accept && produce) begin
                out_valid  <= 1'b1;
                out_window <= next_win;
                out_last   <= last_pix;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    // Line buffers are plain RAM: stale rows are never exposed because of the row gating.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            lb1[cur_col] <= tap_b;
            lb0[cur_col] <= in_pixel;
        end
    end
endmodule
